// File: rtl/pe_column_sequencer.sv
// Weight-stationary PE column sequencer: loads one weight per row, streams skewed activations, tracks results.
// Optional weight reuse (skip LOAD per command) is enabled with PE_SEQ_KEEP_WEIGHTS_EN.
module pe_column_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int LEN_WIDTH  = 8,
  parameter int PE_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LEN_WIDTH-1:0]       cfg_len,
`ifdef PE_SEQ_KEEP_WEIGHTS_EN
  input  logic                       start_keep_w,
`endif
  output logic                       busy,
  output logic                       done,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [DATA_WIDTH-1:0]      w_data,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [DATA_WIDTH*ROWS-1:0] a_data,
  output logic [ROWS-1:0]            pe_store_weight,
  output logic [DATA_WIDTH-1:0]      pe_weight,
  output logic [DATA_WIDTH*ROWS-1:0] pe_data,
  output logic [ROWS-1:0]            pe_valid,
  output logic                       res_valid
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int TRK_D = ROWS - 1 + PE_LATENCY;
  // Every tracker stage except the output one; the output stage may still be high as DRAIN exits.
  localparam logic [TRK_D-1:0] TRK_MASK = {TRK_D{1'b1}} >> 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [ROW_W-1:0]     row_cnt;
  logic [LEN_WIDTH-1:0] vec_cnt;
  logic                 w_fire;
  logic                 a_fire;
  logic                 keep_w;
  logic                 pipe_empty;
  logic [TRK_D-1:0]     trk;
  logic [ROWS-1:0]      row_pending;

  assign w_ready = (state == S_LOAD);
  assign a_ready = (state == S_STREAM);
  assign w_fire  = w_valid & w_ready;
  assign a_fire  = a_valid & a_ready;

`ifdef PE_SEQ_KEEP_WEIGHTS_EN
  assign keep_w = start_keep_w;
`else
  assign keep_w = 1'b0;
`endif

  assign pipe_empty = (row_pending == '0) && ((trk & TRK_MASK) == '0);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (keep_w) state_n = (cfg_len != '0) ? S_STREAM : S_DRAIN;
          else        state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_fire && (row_cnt == ROW_W'(ROWS - 1)))
          state_n = (vec_cnt != '0) ? S_STREAM : S_DRAIN;
      end
      S_STREAM: begin
        if (a_fire && (vec_cnt == LEN_WIDTH'(1))) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (pipe_empty) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      row_cnt <= '0;
      vec_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != S_IDLE);
      done  <= (state_n == S_DONE);
      if ((state == S_IDLE) && start) begin
        vec_cnt <= cfg_len;
        row_cnt <= '0;
      end
      if (w_fire && (row_cnt != ROW_W'(ROWS - 1))) row_cnt <= row_cnt + ROW_W'(1);
      if (a_fire) vec_cnt <= vec_cnt - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pe_store_weight <= '0;
      pe_weight       <= '0;
    end else begin
      pe_store_weight <= '0;
      if (w_fire) begin
        pe_store_weight <= ROWS'(1) << row_cnt;
        pe_weight       <= w_data;
      end
    end
  end

  // Row r is an (r+1)-deep delay line; data only advances with its valid so bubbles hold the value.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_WIDTH-1:0] sd [r+1];
    logic [r:0]            sv;

    always_ff @(posedge clk) begin
      if (rst) begin
        sv <= '0;
        for (int k = 0; k <= r; k++) sd[k] <= '0;
      end else begin
        sv[0] <= a_fire;
        if (a_fire) sd[0] <= a_data[r*DATA_WIDTH +: DATA_WIDTH];
        for (int k = 1; k <= r; k++) begin
          sv[k] <= sv[k-1];
          if (sv[k-1]) sd[k] <= sd[k-1];
        end
      end
    end

    assign pe_valid[r]                         = sv[r];
    assign pe_data[r*DATA_WIDTH +: DATA_WIDTH] = sd[r];
    assign row_pending[r]                      = |sv;
  end

  always_ff @(posedge clk) begin
    if (rst) trk <= '0;
    else     trk <= (trk << 1) | TRK_D'(pe_valid[0]);
  end

  assign res_valid = trk[TRK_D-1];

endmodule

// File: tb/tb_pe_column_sequencer.sv
// Directed bench for pe_column_sequencer: a cycle-indexed handshake-history model plus literal pins.
module tb_pe_column_sequencer;

  localparam int DW   = 8;
  localparam int R    = 4;
  localparam int LW   = 8;
  localparam int PL   = 2;
  localparam int NCYC = 80;
  localparam int MAXC = 128;

  bit              clk;
  logic            rst, start;
  logic [LW-1:0]   cfg_len;
  logic            busy, done;
  logic            w_valid, w_ready;
  logic [DW-1:0]   w_data;
  logic            a_valid, a_ready;
  logic [DW*R-1:0] a_data;
  logic [R-1:0]    pe_store_weight;
  logic [DW-1:0]   pe_weight;
  logic [DW*R-1:0] pe_data;
  logic [R-1:0]    pe_valid;
  logic            res_valid;
`ifdef PE_SEQ_KEEP_WEIGHTS_EN
  logic            start_keep_w;
`endif

  pe_column_sequencer #(.DATA_WIDTH(DW), .ROWS(R), .LEN_WIDTH(LW), .PE_LATENCY(PL)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
`ifdef PE_SEQ_KEEP_WEIGHTS_EN
    .start_keep_w(start_keep_w),
`endif
    .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .pe_store_weight(pe_store_weight), .pe_weight(pe_weight),
    .pe_data(pe_data), .pe_valid(pe_valid), .res_valid(res_valid)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- stimulus table ----------------
  typedef struct packed {
    logic          rst;
    logic          start;
    logic          keep;
    logic [LW-1:0] len;
    logic          wv;
    logic [DW-1:0] wd;
    logic          av;
    logic [31:0]   ad;
  } stim_t;

  stim_t tbl [NCYC];

  task automatic s_start(input int c, input logic [LW-1:0] l);
    tbl[c].start = 1'b1; tbl[c].len = l;
  endtask
  task automatic s_w(input int c, input logic [DW-1:0] d);
    tbl[c].wv = 1'b1; tbl[c].wd = d;
  endtask
  task automatic s_a(input int c, input logic [31:0] d);
    tbl[c].av = 1'b1; tbl[c].ad = d;
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int c = 0; c < NCYC; c++) tbl[c] = '0;
    // reset held with start high, then start accepted on release
    tbl[0].rst = 1'b1; s_start(0, 8'd3);
    tbl[1].rst = 1'b1; s_start(1, 8'd3);
    s_start(2, 8'd3);
    for (int k = 0; k < 4; k++) s_w(3 + k, DW'(k + 1));
    s_a(7, 32'h04030201); s_a(8, 32'h08070605); s_a(9, 32'h0C0B0A09);
    // stalls in both streams, plus an ignored start while busy
    s_start(17, 8'd3);
    s_w(18, 8'h11); tbl[19].wd = 8'hEE; tbl[20].wd = 8'hEE;
    s_w(21, 8'h22); s_w(22, 8'h33); s_w(23, 8'h44);
    s_a(24, 32'h14131211); tbl[25].ad = 32'hEEEEEEEE;
    s_a(26, 32'h18171615); s_a(27, 32'h1C1B1A19);
    s_start(25, 8'd7);
    for (int c = 28; c < 34; c++) s_a(c, 32'hDEADBEEF);
    // start during the done cycle is ignored, the next one is taken; cfg_len = 0
    s_start(34, 8'd0); s_start(35, 8'd0);
    for (int k = 0; k < 4; k++) s_w(36 + k, DW'(k + 5));
    for (int c = 36; c < 42; c++) s_a(c, 32'hFFFFFFFF);
    // reset after the second vector
    s_start(42, 8'd4); s_start(44, 8'd9);
    for (int k = 0; k < 4; k++) s_w(43 + k, DW'(k + 9));
    s_a(47, 32'h24232221); s_a(48, 32'h28272625);
    tbl[49].rst = 1'b1; s_a(49, 32'h2C2B2A29);
    s_start(52, 8'd1);
    for (int k = 0; k < 4; k++) s_w(53 + k, DW'(8'hA1 + k));
    s_a(57, 32'h34333231);
`ifdef PE_SEQ_KEEP_WEIGHTS_EN
    s_start(66, 8'd2); tbl[66].keep = 1'b1;
    s_a(67, 32'h44434241); s_a(68, 32'h48474645);
`endif

    for (int c = 0; c < NCYC; c++) begin
      goto(c);
      rst     = tbl[c].rst;
      start   = tbl[c].start;
      cfg_len = tbl[c].len;
      w_valid = tbl[c].wv;
      w_data  = tbl[c].wd;
      a_valid = tbl[c].av;
      a_data  = tbl[c].ad;
`ifdef PE_SEQ_KEEP_WEIGHTS_EN
      start_keep_w = tbl[c].keep;
`endif
    end
    goto(NCYC);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- behavioural model ----------------
  // History of accepted handshakes per cycle; outputs are derived from timing rules.
  bit            a_hs_at [MAXC];
  logic [31:0]   a_dat_at[MAXC];
  bit            w_hs_at [MAXC];
  int            w_k_at  [MAXC];
  int            base = 1;
  bit            active = 1'b0;
  int            m_len, w_cnt, a_cnt, done_cyc;
  logic [DW-1:0] last_w_dat = '0;
  bit            m_act, e_wr, e_ar, kp;
  int            n;

  function automatic bit hs_at(input int j);
    if (j < base || j < 0 || j >= MAXC) return 1'b0;
    return a_hs_at[j];
  endfunction

  function automatic logic [31:0] exp_pe_data(input int t);
    logic [31:0] v;
    v = '0;
    for (int r = 0; r < R; r++)
      for (int j = t - 1 - r; j >= base && j >= 0; j--)
        if (a_hs_at[j]) begin
          v[r*DW +: DW] = a_dat_at[j][r*DW +: DW];
          break;
        end
    return v;
  endfunction

  function automatic logic [31:0] exp_pe_valid(input int t);
    logic [31:0] v;
    v = '0;
    for (int r = 0; r < R; r++) v[r] = hs_at(t - 1 - r);
    return v;
  endfunction

  function automatic logic [31:0] exp_store(input int t);
    if (t - 1 >= base && w_hs_at[t-1]) return 32'(1) << w_k_at[t-1];
    return '0;
  endfunction

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      n     = cyc;
      m_act = active && (n <= done_cyc);
      e_wr  = m_act && (w_cnt < R);
      e_ar  = m_act && (w_cnt == R) && (a_cnt < m_len);
      chk("busy",            32'(busy),            32'(m_act));
      chk("done",            32'(done),            32'(m_act && (n == done_cyc)));
      chk("w_ready",         32'(w_ready),         32'(e_wr));
      chk("a_ready",         32'(a_ready),         32'(e_ar));
      chk("pe_store_weight", 32'(pe_store_weight), exp_store(n));
      chk("pe_weight",       32'(pe_weight),       32'(last_w_dat));
      chk("pe_data",         pe_data,              exp_pe_data(n));
      chk("pe_valid",        32'(pe_valid),        exp_pe_valid(n));
      chk("res_valid",       32'(res_valid),       32'(hs_at(n - R - PL)));

      a_hs_at[n] = 1'b0;
      w_hs_at[n] = 1'b0;
`ifdef PE_SEQ_KEEP_WEIGHTS_EN
      kp = start_keep_w;
`else
      kp = 1'b0;
`endif
      if (rst) begin
        base       = n + 1;
        active     = 1'b0;
        last_w_dat = '0;
      end else begin
        if (w_valid && e_wr) begin
          w_hs_at[n] = 1'b1;
          w_k_at[n]  = w_cnt;
          last_w_dat = w_data;
          w_cnt++;
          if (w_cnt == R && m_len == 0) done_cyc = n + 2;
        end
        if (a_valid && e_ar) begin
          a_hs_at[n]  = 1'b1;
          a_dat_at[n] = a_data;
          a_cnt++;
          if (a_cnt == m_len) done_cyc = n + R + PL + 1;
        end
        if (start && !m_act) begin
          active   = 1'b1;
          m_len    = int'(cfg_len);
          w_cnt    = kp ? R : 0;
          a_cnt    = 0;
          done_cyc = (kp && m_len == 0) ? n + 2 : 1 << 30;
        end
      end
    end
  end

  // ---------------- hand-computed literal pins ----------------
  task automatic at_cyc(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  initial begin
    at_cyc(1);  chk("pin_rst_busy", 32'(busy), 0); chk("pin_rst_wrdy", 32'(w_ready), 0);
                chk("pin_rst_done", 32'(done), 0);
    at_cyc(2);  chk("pin_rst2_busy", 32'(busy), 0); chk("pin_rst2_data", pe_data, 0);
                chk("pin_rst2_weight", 32'(pe_weight), 0);
    at_cyc(3);  chk("pin_accept_busy", 32'(busy), 1); chk("pin_accept_wrdy", 32'(w_ready), 1);
    at_cyc(4);  chk("pin_store0", 32'(pe_store_weight), 32'h1); chk("pin_weight0", 32'(pe_weight), 1);
    at_cyc(7);  chk("pin_store3", 32'(pe_store_weight), 32'h8); chk("pin_weight3", 32'(pe_weight), 4);
                chk("pin_ardy_up", 32'(a_ready), 1); chk("pin_wrdy_down", 32'(w_ready), 0);
    at_cyc(8);  chk("pin_data_c8", pe_data, 32'h00000001); chk("pin_valid_c8", 32'(pe_valid), 32'h1);
    at_cyc(11); chk("pin_skew_data", pe_data, 32'h04070A09); chk("pin_skew_valid", 32'(pe_valid), 32'hE);
    at_cyc(12); chk("pin_res_early", 32'(res_valid), 0);
    at_cyc(13); chk("pin_res_first", 32'(res_valid), 1);
    at_cyc(15); chk("pin_res_last", 32'(res_valid), 1);
    at_cyc(16); chk("pin_done1", 32'(done), 1); chk("pin_res_after", 32'(res_valid), 0);
    at_cyc(17); chk("pin_idle_busy", 32'(busy), 0); chk("pin_done_pulse", 32'(done), 0);
    at_cyc(20); chk("pin_wstall_store", 32'(pe_store_weight), 0);
    at_cyc(22); chk("pin_store_after_stall", 32'(pe_store_weight), 32'h2);
                chk("pin_weight_after_stall", 32'(pe_weight), 32'h22);
    at_cyc(25); chk("pin_v0_before_gap", 32'(pe_valid[0]), 1);
    at_cyc(26); chk("pin_v0_gap", 32'(pe_valid[0]), 0);
    at_cyc(28); chk("pin_len_kept", 32'(a_ready), 0);
    at_cyc(31); chk("pin_res_gap", 32'(res_valid), 0);
    at_cyc(32); chk("pin_res_after_gap", 32'(res_valid), 1);
    at_cyc(34); chk("pin_done2", 32'(done), 1);
    at_cyc(35); chk("pin_start_in_done_ignored", 32'(busy), 0);
    at_cyc(40); chk("pin_len0_ardy", 32'(a_ready), 0);
    at_cyc(41); chk("pin_len0_done", 32'(done), 1);
    at_cyc(50); chk("pin_midrst_busy", 32'(busy), 0); chk("pin_midrst_res", 32'(res_valid), 0);
                chk("pin_midrst_data", pe_data, 0); chk("pin_midrst_weight", 32'(pe_weight), 0);
                chk("pin_midrst_valid", 32'(pe_valid), 0);
    at_cyc(53); chk("pin_no_pending_res", 32'(res_valid), 0);
    at_cyc(63); chk("pin_post_rst_res", 32'(res_valid), 1);
    at_cyc(64); chk("pin_post_rst_done", 32'(done), 1);
`ifdef PE_SEQ_KEEP_WEIGHTS_EN
    at_cyc(67); chk("pin_keep_ardy", 32'(a_ready), 1); chk("pin_keep_wrdy", 32'(w_ready), 0);
                chk("pin_keep_store", 32'(pe_store_weight), 0);
    at_cyc(75); chk("pin_keep_done", 32'(done), 1);
`endif
  end

endmodule
